// File: rtl/fb_frame_writer.sv
// Ping-pong frame buffer writer: raster pixel stream in, frame RAM writes out, bank handover on display frame tick.
// Optional FB_BINARIZE_EN: threshold each pixel to all-ones/zero against THRESH before writing.
module fb_frame_writer #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 128,
  parameter int PIX_W  = 8,
  parameter int THRESH = 128,
  localparam int AW    = (WIDTH * DEPTH > 1) ? $clog2(WIDTH * DEPTH) : 1
) (
  input  logic            ClkPort,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic            s_sof,
  input  logic            frame_tick,
  output logic            wr_en,
  output logic [AW:0]     wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic            rd_bank,
  output logic            frame_done,
  output logic            sof_err
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, PEND} state_t;

  state_t          state;
  logic [XW-1:0]   xCnt;
  logic [YW-1:0]   yCnt;
  logic [XW-1:0]   curX;
  logic [YW-1:0]   curY;
  logic            doWrite;
  logic            lineEnd;
  logic            lastPix;
  logic [AW-1:0]   offset;
  logic [PIX_W-1:0] pix;

  assign s_ready = (state != PEND);

  // A start-of-frame pixel (from IDLE, or a restart mid-frame) always lands at (0,0).
  // NOTE: always_comb assigns every signal on every path, so no latch can be inferred.
  always_comb begin
    curX    = (state == IDLE || s_sof) ? '0 : xCnt;
    curY    = (state == IDLE || s_sof) ? '0 : yCnt;
    doWrite = s_valid && s_ready && (state == WRITE || s_sof);
    lineEnd = (curX == XW'(WIDTH - 1));
    lastPix = lineEnd && (curY == YW'(DEPTH - 1));
    offset  = AW'(curY) * AW'(WIDTH) + AW'(curX);
`ifdef FB_BINARIZE_EN
    pix     = (s_data >= PIX_W'(THRESH)) ? '1 : '0;
`else
    pix     = s_data;
`endif
  end

`ifndef FB_BINARIZE_EN
  // THRESH only matters to the binarizing build.
  logic unusedThresh;
  assign unusedThresh = (THRESH != 0);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ClkPort or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      xCnt       <= '0;
      yCnt       <= '0;
      rd_bank    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE, WRITE: begin
          if (doWrite) begin
            wr_en   <= 1'b1;
            wr_addr <= {~rd_bank, offset};
            wr_data <= pix;
            if (state == WRITE && s_sof) sof_err <= 1'b1;
            if (lastPix) begin
              xCnt       <= '0;
              yCnt       <= '0;
              frame_done <= 1'b1;
              state      <= PEND;
            end else if (lineEnd) begin
              xCnt  <= '0;
              yCnt  <= curY + YW'(1);
              state <= WRITE;
            end else begin
              xCnt  <= curX + XW'(1);
              yCnt  <= curY;
              state <= WRITE;
            end
          end
        end
        // Hold the finished frame until the display reaches a frame boundary.
        PEND: begin
          if (frame_tick) begin
            rd_bank <= ~rd_bank;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_frame_writer.sv
// Directed bench for fb_frame_writer at WIDTH=4, DEPTH=2: writes are captured on the falling edge and
// compared against hand-written address/data lists.
module tb_fb_frame_writer;

  logic       ClkPort = 1'b0;
  logic       reset;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_sof = 1'b0;
  logic       frame_tick = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_bank;
  logic       frame_done;
  logic       sof_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
    logic       done;
  } wr_t;

  wr_t q[$];
  int  expA[$];
  int  expD[$];

  fb_frame_writer #(.WIDTH(4), .DEPTH(2), .PIX_W(8), .THRESH(128)) dut (
    .ClkPort(ClkPort), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .frame_tick(frame_tick), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 ClkPort = ~ClkPort;

  always @(negedge ClkPort)
    if (wr_en || frame_done) q.push_back('{wr_addr, wr_data, frame_done});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pushPixel(input logic [7:0] d, input logic sof, input logic tick);
    int n;
    @(negedge ClkPort);
    s_valid = 1'b1; s_data = d; s_sof = sof; frame_tick = tick;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge ClkPort);
      n++;
    end
    if (!s_ready) begin
      check("ready_timeout", 32'(s_ready), 32'd1);
      s_valid = 1'b0;
    end else begin
      @(posedge ClkPort);
    end
  endtask

  task automatic drain();
    @(negedge ClkPort);
    s_valid = 1'b0; s_sof = 1'b0; frame_tick = 1'b0;
    repeat (2) @(negedge ClkPort);
  endtask

  task automatic pulseTick();
    @(negedge ClkPort);
    frame_tick = 1'b1;
    @(negedge ClkPort);
    frame_tick = 1'b0;
  endtask

  task automatic checkWrites(input string tag);
    int n;
    n = expA.size();
    check({tag, "_count"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(q[i].a), 32'(expA[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(q[i].d), 32'(expD[i]));
      check($sformatf("%s_done%0d", tag, i), 32'(q[i].done), 32'(i == n - 1));
    end
    q.delete(); expA.delete(); expD.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge ClkPort);
    #1;
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_sof_err", 32'(sof_err), 32'd0);
    @(negedge ClkPort) reset = 1'b1;

    // Frame A to bank1, handover on tick, frame B to bank0.
    for (int i = 0; i < 8; i++) pushPixel(8'h10 + 8'(i), i == 0, 1'b0);
    drain();
    expA = '{8, 9, 10, 11, 12, 13, 14, 15};
    expD = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17};
    checkWrites("frameA");
    check("pend_ready", 32'(s_ready), 32'd0);
    repeat (5) @(negedge ClkPort);
    check("pend_rd_bank", 32'(rd_bank), 32'd0);
    pulseTick();
    check("tickA_rd_bank", 32'(rd_bank), 32'd1);
    check("tickA_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 8; i++) pushPixel(8'h20 + 8'(i), i == 0, 1'b0);
    drain();
    expA = '{0, 1, 2, 3, 4, 5, 6, 7};
    expD = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27};
    checkWrites("frameB");
    pulseTick();
    check("tickB_rd_bank", 32'(rd_bank), 32'd0);

    // Pixels without start-of-frame in IDLE are dropped.
    for (int i = 0; i < 3; i++) pushPixel(8'hE0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pushPixel(8'h50 + 8'(i), i == 0, 1'b0);
    drain();
    expA = '{8, 9, 10, 11, 12, 13, 14, 15};
    expD = '{'h50, 'h51, 'h52, 'h53, 'h54, 'h55, 'h56, 'h57};
    checkWrites("junk");
    pulseTick();
    check("tickC_rd_bank", 32'(rd_bank), 32'd1);

    // Start-of-frame on the 6th pixel restarts the frame in bank0.
    for (int i = 0; i < 13; i++) pushPixel(8'h30 + 8'(i), i == 0 || i == 5, 1'b0);
    drain();
    expA = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 6, 7};
    expD = '{'h30, 'h31, 'h32, 'h33, 'h34, 'h35, 'h36, 'h37, 'h38, 'h39, 'h3A, 'h3B, 'h3C};
    checkWrites("sofmid");
    check("sof_err_set", 32'(sof_err), 32'd1);
    pulseTick();
    check("tickD_rd_bank", 32'(rd_bank), 32'd0);
    check("sof_err_sticky", 32'(sof_err), 32'd1);

    // Gapped valid, tick during WRITE and tick coincident with the last accept.
    for (int i = 0; i < 8; i++) begin
      pushPixel(8'h40 + 8'(i), i == 0, i == 7);
      @(negedge ClkPort);
      s_valid = 1'b0; frame_tick = (i == 3);
      if (i == 4) check("write_tick_rd_bank", 32'(rd_bank), 32'd0);
    end
    drain();
    expA = '{8, 9, 10, 11, 12, 13, 14, 15};
    expD = '{'h40, 'h41, 'h42, 'h43, 'h44, 'h45, 'h46, 'h47};
    checkWrites("gapped");
    check("lasttick_rd_bank", 32'(rd_bank), 32'd0);
    check("lasttick_ready", 32'(s_ready), 32'd0);
    pulseTick();
    check("tickE_rd_bank", 32'(rd_bank), 32'd1);

    // Reset after 5 pixels abandons the frame and returns rd_bank to 0.
    for (int i = 0; i < 5; i++) pushPixel(8'h60 + 8'(i), i == 0, 1'b0);
    @(negedge ClkPort);
    s_valid = 1'b0; s_sof = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_writes", 32'(q.size()), 32'd5);
    check("mid_wr_en", 32'(wr_en), 32'd0);
    check("mid_addr", 32'(wr_addr), 32'd0);
    check("mid_rd_bank", 32'(rd_bank), 32'd0);
    check("mid_sof_err", 32'(sof_err), 32'd0);
    check("mid_ready", 32'(s_ready), 32'd1);
    q.delete();
    @(negedge ClkPort) reset = 1'b1;

    // Frame after reset goes to bank1 from offset 0; exercises binarizing.
    expD = '{'h7F, 'h80, 'h00, 'hFF, 'h01, 'hFE, 'h7F, 'h80};
    for (int i = 0; i < 8; i++) pushPixel(8'(expD[i]), i == 0, 1'b0);
    drain();
`ifdef FB_BINARIZE_EN
    expD = '{'h00, 'hFF, 'h00, 'hFF, 'h00, 'hFF, 'h00, 'hFF};
`endif
    expA = '{8, 9, 10, 11, 12, 13, 14, 15};
    checkWrites("binarize");
    pulseTick();
    check("tickF_rd_bank", 32'(rd_bank), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
